// File: rtl/time_counter.sv
// rtl/time_counter.sv - time-of-day counter (hh:mm:ss) with prescaler, load and tick pulses
//
// Ports:
//   clk_100MHz_i    in   system clock, rising edge
//   reset_n_i       in   synchronous active-low reset
//   count_enable_i  in   time advances while high
//   load_time_i     in   single-cycle request to load load_* into the time
//   load_seconds_i  in   [5:0] seconds to load (>59 loads as 0)
//   load_minutes_i  in   [5:0] minutes to load (>59 loads as 0)
//   load_hours_i    in   [4:0] hours to load (>23 loads as 0)
//   seconds_o       out  [5:0] current seconds 0..59
//   minutes_o       out  [5:0] current minutes 0..59
//   hours_o         out  [4:0] current hours 0..23
//   tick_1hz_o      out  one-cycle pulse in the first cycle a new second is visible
//   day_wrap_o      out  one-cycle pulse alongside the 23:59:59 -> 00:00:00 tick
module time_counter #(
  parameter int CLK_DIV = 100000000
) (
  input  logic       clk_100MHz_i,
  input  logic       reset_n_i,
  input  logic       count_enable_i,
  input  logic       load_time_i,
  input  logic [5:0] load_seconds_i,
  input  logic [5:0] load_minutes_i,
  input  logic [4:0] load_hours_i,
  output logic [5:0] seconds_o,
  output logic [5:0] minutes_o,
  output logic [4:0] hours_o,
  output logic       tick_1hz_o,
  output logic       day_wrap_o
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic          terminal;
  logic          sec_max;
  logic          min_max;
  logic          hr_max;

  assign terminal = count_enable_i && (presc == PRESC_MAX);
  assign sec_max  = (seconds_o == 6'd59);
  assign min_max  = (minutes_o == 6'd59);
  assign hr_max   = (hours_o == 5'd23);

  // Every field lives in the same always_ff so a carry chain lands on one edge.
  always_ff @(posedge clk_100MHz_i) begin
    if (!reset_n_i) begin
      presc      <= '0;
      seconds_o  <= '0;
      minutes_o  <= '0;
      hours_o    <= '0;
      tick_1hz_o <= 1'b0;
      day_wrap_o <= 1'b0;
    end else begin
      tick_1hz_o <= 1'b0;
      day_wrap_o <= 1'b0;
      if (load_time_i) begin
        // Load beats a coinciding terminal event: no increment, no tick.
        presc     <= '0;
        seconds_o <= (load_seconds_i > 6'd59) ? 6'd0 : load_seconds_i;
        minutes_o <= (load_minutes_i > 6'd59) ? 6'd0 : load_minutes_i;
        hours_o   <= (load_hours_i > 5'd23) ? 5'd0 : load_hours_i;
      end else if (terminal) begin
        presc      <= '0;
        tick_1hz_o <= 1'b1;
        day_wrap_o <= sec_max && min_max && hr_max;
        seconds_o  <= sec_max ? 6'd0 : seconds_o + 6'd1;
        if (sec_max) begin
          minutes_o <= min_max ? 6'd0 : minutes_o + 6'd1;
          if (min_max) begin
            hours_o <= hr_max ? 5'd0 : hours_o + 5'd1;
          end
        end
      end else if (count_enable_i) begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100000000, giving clock cycles per counted second (legal range 2 and above).
REQ-002 The block SHALL have port clk_100MHz_i, input, 1 bit, the system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port reset_n_i, input, 1 bit, a synchronous active-low reset.
REQ-004 The block SHALL have port count_enable_i, input, 1 bit; when high, time advances.
REQ-005 The block SHALL have port load_time_i, input, 1 bit, a single-cycle request to load the time.
REQ-006 The block SHALL have port load_seconds_i, input, 6 bits, the seconds value to load.
REQ-007 The block SHALL have port load_minutes_i, input, 6 bits, the minutes value to load.
REQ-008 The block SHALL have port load_hours_i, input, 5 bits, the hours value to load.
REQ-009 The block SHALL have port seconds_o, output, 6 bits, the current seconds (0..59).
REQ-010 The block SHALL have port minutes_o, output, 6 bits, the current minutes (0..59).
REQ-011 The block SHALL have port hours_o, output, 5 bits, the current hours (0..23).
REQ-012 The block SHALL have port tick_1hz_o, output, 1 bit, a one-cycle pulse on each seconds advance.
REQ-013 The block SHALL have port day_wrap_o, output, 1 bit, a one-cycle pulse on the 23:59:59 to 00:00:00 rollover.

Function
REQ-014 The block SHALL contain a prescaler counting 0..CLK_DIV-1, sized as ceil(log2(CLK_DIV)) bits.
REQ-015 The prescaler SHALL increment by 1 per cycle only while count_enable_i=1 and load_time_i=0, and SHALL hold its value while count_enable_i=0.
REQ-016 The prescaler SHALL return to 0 on the cycle after it holds CLK_DIV-1 with an increment enabled; this is the terminal event.
REQ-017 On the terminal event, seconds SHALL advance by 1 on the same clock edge; at 59, seconds SHALL become 0 and minutes SHALL carry.
REQ-018 On a minutes carry, minutes SHALL advance by 1; at 59, minutes SHALL become 0 and hours SHALL carry.
REQ-019 On an hours carry, hours SHALL advance by 1; at 23, hours SHALL become 0.
REQ-020 All fields SHALL update on a single edge; no output SHALL ever show an intermediate value.
REQ-021 tick_1hz_o SHALL be registered and high for exactly the first cycle in which the new time is visible on the outputs.
REQ-022 day_wrap_o SHALL be registered and high in that same cycle only when the transition was 23:59:59 to 00:00:00.
REQ-023 Sequence: prescaler at CLK_DIV-1 at edge N gives new time and tick_1hz_o=1 in the cycle after edge N.
REQ-024 load_time_i=1 SHALL, on that edge, copy the load_* inputs into the time registers and clear the prescaler to 0, regardless of count_enable_i.
REQ-025 On that load edge, tick_1hz_o and day_wrap_o SHALL be 0 in the following cycle.
REQ-026 When load_time_i and the terminal event coincide, the load SHALL win: the loaded value is not incremented and no tick is produced.
REQ-027 An out-of-range load field (seconds or minutes >59, hours >23) SHALL load as 0; the in-range fields of the same load SHALL load normally.
REQ-028 After a load, the first advance SHALL occur exactly CLK_DIV enabled cycles later.
REQ-029 count_enable_i going low mid-second SHALL freeze the prescaler; re-enabling SHALL resume the count from the frozen value, with the partial second kept.
REQ-030 Outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-031 With reset_n_i=0 at a rising edge, seconds_o, minutes_o, hours_o, prescaler, tick_1hz_o and day_wrap_o SHALL all become 0.
REQ-032 Reset SHALL take priority over load_time_i and count_enable_i.
REQ-033 Reset asserted mid-second SHALL discard the partial prescaler count.
REQ-034 Releasing reset with count_enable_i=1 SHALL produce the first tick after exactly CLK_DIV enabled cycles.

Verification (run with CLK_DIV=4)
REQ-035 Scenario 1: reset then enable held high for 12 cycles -> time 00:00:03; tick_1hz_o pulses 3 times, 4 cycles apart, each 1 cycle wide.
REQ-036 Scenario 2: load 23:59:59, then enable for 4 cycles -> time 00:00:00, with tick_1hz_o=1 and day_wrap_o=1 in the same single cycle.
REQ-037 Scenario 3: load 10:59:59 and run 1 s -> 11:00:00 with day_wrap_o=0; load 00:00:58, run 2 s -> 00:01:00.
REQ-038 Scenario 4: load_time_i asserted in the terminal-event cycle with load 05:06:07 -> outputs 05:06:07, no tick; next tick after 4 more enabled cycles -> 05:06:08.
REQ-039 Scenario 5: enable for 2 cycles, disable for 10 cycles, re-enable -> tick occurs after 2 further enabled cycles; time frozen at 00:00:00 while disabled.
REQ-040 Scenario 6: load 24:60:61 -> 00:00:00; load 07:60:30 -> 07:00:30; reset_n_i low during a running count -> all outputs 0 on the next cycle.
